serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_pkg.sv | 13 +
 rtl/fa_cell.sv | 16 +
 rtl/serial_add_ctrl.sv | 146 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding and the default operand width.
package serial_add_pkg;

  localparam int SERIAL_ADD_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// Single-bit full-adder cell used by the serial adder datapath.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of one bit position.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: loads two operands and a carry-in, then feeds
// one bit pair per clock through a single fa_cell, LSB first. The sum is
// shifted in from the top so that it lines up after WIDTH cycles.
//
// Optional build macro SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for start; sum/cout hold the last result
// ST_RUN  | one bit pair per cycle through the full-adder (busy=1)
// ST_DONE | result valid for one cycle (done=1); start here reloads
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic             load;
  logic             shift;
  logic             last_bit;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [CNT_W-1:0] cnt_q;

  logic             fa_s;
  logic             fa_co;

  fa_cell u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt_q == LAST_BIT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and control strobes; start is only honoured in IDLE/DONE.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (last_bit) state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand shift registers, running carry and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (load) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (shift) begin
      a_q     <= {1'b0, a_q[WIDTH-1:1]};
      b_q     <= {1'b0, b_q[WIDTH-1:1]};
      carry_q <= fa_co;
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Result register: sum bits enter at the MSB; final carry captured on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (shift) begin
      sum_q <= {fa_s, sum_q[WIDTH-1:1]};
      if (last_bit) cout_q <= fa_co;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // Signed overflow: on the MSB cycle carry_q is the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ovf_q <= 1'b0;
    else if (shift && last_bit) ovf_q <= carry_q ^ fa_co;
  end

  assign ovf = ovf_q;
`endif

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with WIDTH=8.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       cin = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int failures = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Start one addition and watch it to the done pulse. Optionally inject a
  // start with other operands on cycle inject_cyc (RUN cycles are 1..8).
  task automatic do_add(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input int inject_cyc, output int lat, output int nbusy,
                        output int overlap);
    @(negedge clk);
    start = 1'b1; a = av; b = bv; cin = cv;
    lat = 0; nbusy = 0; overlap = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == inject_cyc) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (busy) nbusy++;
      if (busy && done) overlap++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (sum !== 8'h00 || cout !== 1'b0) begin
      failures++;
      $display("FAIL reset_result sum=%h cout=%b required 00 0", sum, cout);
    end
`ifdef SERIAL_ADD_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf ovf=%b required 0", ovf);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, nbusy, ov;
    do_add(8'h5A, 8'h33, 1'b0, 0, lat, nbusy, ov);
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("FAIL basic_latency got=%0d required 9", lat);
    end
    checks++;
    if (nbusy !== 8 || ov !== 0) begin
      failures++;
      $display("FAIL basic_busy busy_cycles=%0d overlap=%0d required 8 0", nbusy, ov);
    end
    checks++;
    if (sum !== 8'h8D || cout !== 1'b0) begin
      failures++;
      $display("FAIL basic_sum sum=%h cout=%b required 8d 0", sum, cout);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h8D) begin
      failures++;
      $display("FAIL basic_hold done=%b busy=%b sum=%h required 0 0 8d", done, busy, sum);
    end
  endtask

  task automatic test_carry_cases();
    int lat, nbusy, ov;
    do_add(8'hFF, 8'h01, 1'b0, 0, lat, nbusy, ov);
    checks++;
    if (lat !== 9 || sum !== 8'h00 || cout !== 1'b1) begin
      failures++;
      $display("FAIL carry_ff01 lat=%0d sum=%h cout=%b required 9 00 1", lat, sum, cout);
    end
`ifdef SERIAL_ADD_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_ff01 ovf=%b required 0", ovf);
    end
`endif
    do_add(8'h00, 8'h00, 1'b1, 0, lat, nbusy, ov);
    checks++;
    if (lat !== 9 || sum !== 8'h01 || cout !== 1'b0) begin
      failures++;
      $display("FAIL cin_only lat=%0d sum=%h cout=%b required 9 01 0", lat, sum, cout);
    end
    do_add(8'h7F, 8'h01, 1'b0, 0, lat, nbusy, ov);
    checks++;
    if (lat !== 9 || sum !== 8'h80 || cout !== 1'b0) begin
      failures++;
      $display("FAIL add_7f01 lat=%0d sum=%h cout=%b required 9 80 0", lat, sum, cout);
    end
`ifdef SERIAL_ADD_OVF_EN
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_7f01 ovf=%b required 1", ovf);
    end
`endif
  endtask

  task automatic test_start_ignored();
    int lat, nbusy, ov;
    do_add(8'h10, 8'h20, 1'b0, 3, lat, nbusy, ov);
    checks++;
    if (lat !== 9 || nbusy !== 8) begin
      failures++;
      $display("FAIL ignore_timing lat=%0d busy_cycles=%0d required 9 8", lat, nbusy);
    end
    checks++;
    if (sum !== 8'h30 || cout !== 1'b0) begin
      failures++;
      $display("FAIL ignore_sum sum=%h cout=%b required 30 0", sum, cout);
    end
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    int nbusy = 0;
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h33; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    // Raise start with the second operands during RUN and hold it through DONE.
    for (int i = 2; i <= 9; i++) begin
      @(negedge clk);
      if (i == 7) begin
        start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
      end
    end
    checks++;
    if (done !== 1'b1 || sum !== 8'h8D) begin
      failures++;
      $display("FAIL b2b_first done=%b sum=%h required 1 8d", done, sum);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_idle busy=%b done=%b required 1 0", busy, done);
    end
    for (int i = 2; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 9 || sum !== 8'h02 || cout !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second lat=%0d sum=%h cout=%b required 9 02 0", lat, sum, cout);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nbusy, ov;
    logic seen;
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h33; cin = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre busy=%b required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_clear busy=%b done=%b sum=%h cout=%b required 0 0 00 0",
               busy, done, sum, cout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_no_done activity=%b required 0", seen);
    end
    do_add(8'h5A, 8'h33, 1'b1, 0, lat, nbusy, ov);
    checks++;
    if (lat !== 9 || sum !== 8'h8E || cout !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_after lat=%0d sum=%h cout=%b required 9 8e 0", lat, sum, cout);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_cases();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
